// File: rtl/pcie_wd_pkg.sv
// Shared types and constants for the PCIe link watchdog.
// The optional idle detector is enabled by defining PCIE_WD_ACTIVITY_EN.
package pcie_wd_pkg;

    localparam int unsigned SYM_W      = 10;
    localparam int unsigned CAUSE_ABS  = 0;
    localparam int unsigned CAUSE_IDLE = 1;

    typedef enum logic [1:0] {
        ST_HOLD    = 2'd0,
        ST_RELEASE = 2'd1,
        ST_RUN     = 2'd2,
        ST_TIMEOUT = 2'd3
    } wd_state_e;

    typedef logic [31:0] wd_count_t;

    // Increment that sticks at all-ones
    function automatic wd_count_t sat_inc(wd_count_t c);
        return (c == '1) ? c : wd_count_t'(c + 32'd1);
    endfunction

endpackage

// File: rtl/pcie_link_activity.sv
// Per-link activity detector: flags any lane symbol change versus the previous cycle.
// Instantiated by pcie_link_watchdog only when PCIE_WD_ACTIVITY_EN is defined.
module pcie_link_activity
    import pcie_wd_pkg::*;
#(
    parameter int unsigned NUM_LANES = 16
) (
    input  logic                         i_clk,
    input  logic                         i_rst,
    input  logic [NUM_LANES*SYM_W-1:0]   i_symbols,
    output logic                         o_change_c
);

    logic [NUM_LANES*SYM_W-1:0] r_hist;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) r_hist <= '0;
        else       r_hist <= i_symbols;
    end

    assign o_change_c = (i_symbols != r_hist);

endmodule

// File: rtl/pcie_link_watchdog.sv
// Staggered per-link reset sequencer with absolute run-time watchdog.
// Define PCIE_WD_ACTIVITY_EN to add the link-idle timeout (TimeoutCause[1]).
module pcie_link_watchdog
    import pcie_wd_pkg::*;
#(
    parameter int unsigned NUM_LINKS      = 2,
    parameter int unsigned NUM_LANES      = 16,
    parameter int unsigned RESET_CYCLES   = 10,
    parameter int unsigned STAGGER        = 4,
    parameter int unsigned TIMEOUT_CYCLES = 1000000,
    parameter int unsigned IDLE_CYCLES    = 5000
) (
    input  logic                                 Clk,
    input  logic                                 Reset,
    input  logic [NUM_LINKS*NUM_LANES*SYM_W-1:0] Link,
    input  logic                                 Restart,
    output logic [NUM_LINKS-1:0]                 notResetOut,
    output logic [31:0]                          CycleCount,
    output logic                                 Timeout,
    output logic [1:0]                           TimeoutCause,
    output logic                                 Fatal
);

    localparam int unsigned LINK_W      = NUM_LANES * SYM_W;
    localparam int unsigned LAST_REL    = STAGGER * (NUM_LINKS - 1);
    localparam wd_count_t   LAST_REL_C  = wd_count_t'(LAST_REL);
    localparam wd_count_t   RESET_LIM   = wd_count_t'(RESET_CYCLES);
    localparam wd_count_t   TIMEOUT_LIM = wd_count_t'(TIMEOUT_CYCLES);

    if (NUM_LINKS < 1 || NUM_LINKS > 8) begin : g_bad_links
        $error("pcie_link_watchdog: NUM_LINKS must be 1..8");
    end
    if (NUM_LANES < 1 || NUM_LANES > 16) begin : g_bad_lanes
        $error("pcie_link_watchdog: NUM_LANES must be 1..16");
    end
    if (TIMEOUT_CYCLES <= RESET_CYCLES + LAST_REL) begin : g_bad_timeout
        $error("pcie_link_watchdog: TIMEOUT_CYCLES must exceed RESET_CYCLES + STAGGER*(NUM_LINKS-1)");
    end

    wd_state_e              r_state, w_state_nx;
    wd_count_t              r_count, w_count_nx;
    wd_count_t              r_rel_cnt, w_rel_nx;
    logic [NUM_LINKS-1:0]   r_nrst, w_nrst_nx;
    logic                   r_timeout, w_timeout_nx;
    logic [1:0]             r_cause, w_cause_nx;
    logic                   r_fatal, w_fatal_nx;
    wd_count_t              w_count_inc;
    logic                   w_abs_hit;
    logic                   w_idle_hit;

    // Link k is released once the release counter reaches STAGGER*k
    function automatic logic [NUM_LINKS-1:0] release_mask(wd_count_t rel);
        logic [NUM_LINKS-1:0] m;
        m = '0;
        for (int unsigned k = 0; k < NUM_LINKS; k++) begin
            m[k] = (rel >= wd_count_t'(STAGGER * k));
        end
        return m;
    endfunction

`ifdef PCIE_WD_ACTIVITY_EN
    logic [NUM_LINKS-1:0]   w_change;
    logic                   w_any_change;
    wd_count_t              r_idle;
    wd_count_t              w_idle_inc;

    for (genvar k = 0; k < NUM_LINKS; k++) begin : g_act
        pcie_link_activity #(
            .NUM_LANES (NUM_LANES)
        ) u_act (
            .i_clk      (Clk),
            .i_rst      (Reset),
            .i_symbols  (Link[k*LINK_W +: LINK_W]),
            .o_change_c (w_change[k])
        );
    end

    assign w_any_change = |(w_change & r_nrst);
    assign w_idle_inc   = (r_state == ST_RUN && !w_any_change) ? wd_count_t'(r_idle + 32'd1) : '0;
    assign w_idle_hit   = (r_state == ST_RUN) && (w_idle_inc == wd_count_t'(IDLE_CYCLES));

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset)        r_idle <= '0;
        else if (Restart) r_idle <= '0;
        else              r_idle <= w_idle_inc;
    end
`else
    localparam int unsigned unused_idle_cycles = IDLE_CYCLES;
    logic w_unused_link;

    assign w_unused_link = ^Link;
    assign w_idle_hit    = 1'b0;
`endif

    // Timeout is taken on the edge where the count reaches the limit,
    // so Fatal is seen while CycleCount == TIMEOUT_CYCLES.
    assign w_count_inc = sat_inc(r_count);
    assign w_abs_hit   = (r_state != ST_TIMEOUT) && (w_count_inc == TIMEOUT_LIM);

    always_comb begin
        w_state_nx   = r_state;
        w_count_nx   = w_count_inc;
        w_rel_nx     = r_rel_cnt;
        w_nrst_nx    = r_nrst;
        w_timeout_nx = r_timeout;
        w_cause_nx   = r_cause;
        w_fatal_nx   = 1'b0;

        case (r_state)
            ST_HOLD: begin
                if (r_count == RESET_LIM) begin
                    w_state_nx = ST_RELEASE;
                    w_rel_nx   = '0;
                    w_nrst_nx  = release_mask('0);
                end
            end
            ST_RELEASE: begin
                if (&r_nrst) begin
                    w_state_nx = ST_RUN;
                end else begin
                    w_rel_nx  = (r_rel_cnt < LAST_REL_C) ? wd_count_t'(r_rel_cnt + 32'd1) : r_rel_cnt;
                    w_nrst_nx = r_nrst | release_mask(w_rel_nx);
                end
            end
            default: ;
        endcase

        if (w_abs_hit || w_idle_hit) begin
            w_state_nx              = ST_TIMEOUT;
            w_nrst_nx               = r_nrst;
            w_timeout_nx            = 1'b1;
            w_fatal_nx              = 1'b1;
            w_cause_nx[CAUSE_ABS]   = r_cause[CAUSE_ABS] | w_abs_hit;
            w_cause_nx[CAUSE_IDLE]  = r_cause[CAUSE_IDLE] | w_idle_hit;
        end

        // Restart overrides every other transition, including a coincident timeout
        if (Restart) begin
            w_state_nx   = ST_HOLD;
            w_count_nx   = '0;
            w_rel_nx     = '0;
            w_nrst_nx    = '0;
            w_timeout_nx = 1'b0;
            w_cause_nx   = '0;
            w_fatal_nx   = 1'b0;
        end
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            r_state   <= ST_HOLD;
            r_count   <= '0;
            r_rel_cnt <= '0;
            r_nrst    <= '0;
            r_timeout <= 1'b0;
            r_cause   <= '0;
            r_fatal   <= 1'b0;
        end else begin
            r_state   <= w_state_nx;
            r_count   <= w_count_nx;
            r_rel_cnt <= w_rel_nx;
            r_nrst    <= w_nrst_nx;
            r_timeout <= w_timeout_nx;
            r_cause   <= w_cause_nx;
            r_fatal   <= w_fatal_nx;
        end
    end

    assign notResetOut  = r_nrst;
    assign CycleCount   = r_count;
    assign Timeout      = r_timeout;
    assign TimeoutCause = r_cause;
    assign Fatal        = r_fatal;

endmodule

// File: tb/tb_pcie_link_watchdog.sv
// Directed + randomized bench for pcie_link_watchdog with a cycle-level reference model.
// Idle-timeout expectations apply when PCIE_WD_ACTIVITY_EN is defined.
module tb_pcie_link_watchdog;

    localparam int unsigned NL   = 2;
    localparam int unsigned NLA  = 4;
    localparam int unsigned R    = 10;
    localparam int unsigned S    = 4;
    localparam int unsigned TO   = 200;
    localparam int unsigned IDLE = 50;
    localparam int unsigned LW   = NL * NLA * 10;
    localparam int unsigned RUN_START = R + S * (NL - 1) + 2;

    logic           Clk = 1'b0;
    logic           Reset;
    logic           Restart;
    logic [LW-1:0]  Link;
    logic [NL-1:0]  notResetOut;
    logic [31:0]    CycleCount;
    logic           Timeout;
    logic [1:0]     TimeoutCause;
    logic           Fatal;

    pcie_link_watchdog #(
        .NUM_LINKS      (NL),
        .NUM_LANES      (NLA),
        .RESET_CYCLES   (R),
        .STAGGER        (S),
        .TIMEOUT_CYCLES (TO),
        .IDLE_CYCLES    (IDLE)
    ) dut (
        .Clk          (Clk),
        .Reset        (Reset),
        .Link         (Link),
        .Restart      (Restart),
        .notResetOut  (notResetOut),
        .CycleCount   (CycleCount),
        .Timeout      (Timeout),
        .TimeoutCause (TimeoutCause),
        .Fatal        (Fatal)
    );

    always #5 Clk = ~Clk;

    int tests = 0;
    int fails = 0;
    int n_fatal = 0;

    // Reference model: cycles since reset/restart, sticky timeout, idle run length
    int unsigned   m_cnt;
    int unsigned   m_idle;
    bit            m_to;
    bit [1:0]      m_cause;
    bit            m_fatal;
    logic [LW-1:0] m_prev;

    function automatic logic [NL-1:0] exp_nrst(int unsigned c);
        logic [NL-1:0] m;
        for (int k = 0; k < NL; k++) m[k] = (c >= R + 1 + S * k);
        return m;
    endfunction

    function automatic logic [LW-1:0] rnd_link();
        logic [95:0] t;
        t = {$urandom, $urandom, $urandom};
        return t[LW-1:0];
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_cnt = 0; m_idle = 0; m_to = 0; m_cause = 2'b00; m_fatal = 0; m_prev = '0;
    endtask

    task automatic model_edge();
        bit run, abs_hit, idle_hit;
        int unsigned new_cnt;
        if (Reset) begin
            model_reset();
        end else if (Restart) begin
            m_cnt = 0; m_idle = 0; m_to = 0; m_cause = 2'b00; m_fatal = 0;
            m_prev = Link;
        end else begin
            run      = !m_to && (m_cnt >= RUN_START);
            new_cnt  = (m_cnt == 32'hFFFF_FFFF) ? m_cnt : m_cnt + 1;
            idle_hit = 1'b0;
`ifdef PCIE_WD_ACTIVITY_EN
            m_idle   = run ? ((Link == m_prev) ? m_idle + 1 : 0) : 0;
            idle_hit = run && (m_idle == IDLE);
`endif
            abs_hit  = !m_to && (new_cnt == TO);
            m_fatal  = abs_hit || idle_hit;
            if (m_fatal) begin
                m_to = 1'b1;
                m_cause[0] = m_cause[0] | abs_hit;
                m_cause[1] = m_cause[1] | idle_hit;
            end
            m_cnt  = new_cnt;
            m_prev = Link;
        end
    endtask

    task automatic check_all();
        chk("count",  CycleCount, m_cnt);
        chk("nrst",   32'(notResetOut), 32'(exp_nrst(m_cnt)));
        chk("timeout", 32'(Timeout), 32'(m_to));
        chk("cause",  32'(TimeoutCause), 32'(m_cause));
        chk("fatal",  32'(Fatal), 32'(m_fatal));
    endtask

    task automatic step();
        @(posedge Clk);
        model_edge();
        #1;
        check_all();
        if (Fatal === 1'b1) n_fatal++;
    endtask

    task automatic run_until(input int unsigned target, input bit freeze);
        int guard;
        guard = 0;
        while (m_cnt != target && guard < 2000) begin
            if (!freeze) Link = rnd_link();
            step();
            guard++;
        end
        chk("reach_count", CycleCount, target);
    endtask

    initial begin
        Reset = 1'b1; Restart = 1'b0; Link = '0;
        model_reset();
        #1;
        check_all();
        repeat (3) step();

        // Release reset just after an edge; first increment on the next edge
        Reset = 1'b0;
        while (m_cnt < 13) begin
            Link = rnd_link();
            step();
            if (m_cnt == 11) chk("link0_rise", 32'(notResetOut), 32'h1);
            if (m_cnt == 15) chk("link1_rise", 32'(notResetOut), 32'h3);
        end

        // Restart in the middle of the release sequence
        Restart = 1'b1;
        step();
        Restart = 1'b0;
        chk("restart_count", CycleCount, 32'd0);
        chk("restart_nrst", 32'(notResetOut), 32'd0);
        run_until(100, 1'b0);
        chk("nrst_all_run", 32'(notResetOut), 32'h3);

        // Freeze links and run far beyond any timeout
        n_fatal = 0;
        run_until(TO + 100, 1'b1);
        chk("fatal_pulses", 32'(n_fatal), 32'd1);
        chk("timeout_sticky", 32'(Timeout), 32'd1);
`ifdef PCIE_WD_ACTIVITY_EN
        chk("cause_idle", 32'(TimeoutCause), 32'h2);
`else
        chk("cause_abs", 32'(TimeoutCause), 32'h1);
`endif

        // Restart out of TIMEOUT, then Restart coincident with absolute expiry
        Restart = 1'b1;
        step();
        Restart = 1'b0;
        chk("clear_timeout", 32'(Timeout), 32'd0);
        run_until(TO - 1, 1'b0);
        Restart = 1'b1;
        step();
        Restart = 1'b0;
        chk("coinc_no_fatal", 32'(Fatal), 32'd0);
        chk("coinc_count", CycleCount, 32'd0);
        chk("coinc_no_timeout", 32'(Timeout), 32'd0);

        // Asynchronous reset during RUN, checked before any clock edge
        run_until(40, 1'b0);
        #2;
        Reset = 1'b1;
        #1;
        model_reset();
        check_all();
        repeat (2) step();
        Reset = 1'b0;

        // Random phase: bursty link activity, rare restarts
        n_fatal = 0;
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(7) == 0) Link = rnd_link();
            Restart = ($urandom_range(399) == 0);
            step();
        end
        Restart = 1'b0;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
